// File: rtl/priv_1_12_clint.sv
// Core-local interruptor: mtime/mtimecmp/msip on a request/ack bus, plus one-cycle
// set/clear pulses on the timer and software pending edges.
module priv_1_12_clint #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        timer_int_m,
  output logic        clear_timer_int_m,
  output logic        soft_int_m,
  output logic        clear_soft_int_m
);

  localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {StIdle, StResp} state_e;

  state_e              state_q;
  logic [PrescW-1:0]   presc_q, presc_d;
  logic [63:0]         mtime_q, mtime_d;
  logic [63:0]         mtimecmp_q, mtimecmp_d;
  logic                msip_q, msip_d;
  logic                tpend_q, spend_q;

  logic [31:0] offset;
  logic        in_win, aligned;
  logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi, sel_any;
  logic        req, bad, wr_en, tick, cmp;
  logic [31:0] rd_val;

  function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                        input logic [3:0] be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

  // Address decode straight from the bus; reads and writes both resolve on the accept edge.
  assign offset      = addr - BASE_ADDR;
  assign in_win      = (offset[31:16] == 16'h0000);
  assign aligned     = (addr[1:0] == 2'b00);
  assign sel_msip    = in_win && aligned && (offset[15:0] == 16'h0000);
  assign sel_cmp_lo  = in_win && aligned && (offset[15:0] == 16'h4000);
  assign sel_cmp_hi  = in_win && aligned && (offset[15:0] == 16'h4004);
  assign sel_time_lo = in_win && aligned && (offset[15:0] == 16'hBFF8);
  assign sel_time_hi = in_win && aligned && (offset[15:0] == 16'hBFFC);
  assign sel_any     = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_time_lo | sel_time_hi;

  assign req   = (state_q == StIdle) && (ren || wen);
  assign bad   = !sel_any || (ren && wen);
  assign wr_en = req && wen && !bad;
  assign tick  = (presc_q == PrescW'(TICK_DIV - 1));
  assign cmp   = (mtime_q >= mtimecmp_q);

  always_comb begin
    rd_val = '0;
    if (sel_msip)         rd_val = {31'b0, msip_q};
    else if (sel_cmp_lo)  rd_val = mtimecmp_q[31:0];
    else if (sel_cmp_hi)  rd_val = mtimecmp_q[63:32];
    else if (sel_time_lo) rd_val = mtime_q[31:0];
    else if (sel_time_hi) rd_val = mtime_q[63:32];
  end

  always_comb begin
    presc_d    = tick ? '0 : presc_q + PrescW'(1);
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    // A write to either mtime half suppresses that cycle's increment entirely.
    if (wr_en && sel_time_lo)      mtime_d[31:0]  = merge(mtime_q[31:0], wdata, byte_en);
    else if (wr_en && sel_time_hi) mtime_d[63:32] = merge(mtime_q[63:32], wdata, byte_en);
    else if (tick)                 mtime_d        = mtime_q + 64'd1;
    if (wr_en && sel_cmp_lo) mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], wdata, byte_en);
    if (wr_en && sel_cmp_hi) mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], wdata, byte_en);
    if (wr_en && sel_msip && byte_en[0]) msip_d = wdata[0];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ren || wen) begin
            state_q <= StResp;
            rdata   <= (ren && !bad) ? rd_val : '0;
            err     <= bad;
          end
        end
        StResp: begin
          state_q <= StIdle;
          rdata   <= '0;
          err     <= 1'b0;
        end
      endcase
    end
  end

  assign ack = (state_q == StResp);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tpend_q           <= 1'b0;
      spend_q           <= 1'b0;
      timer_int_m       <= 1'b0;
      clear_timer_int_m <= 1'b0;
      soft_int_m        <= 1'b0;
      clear_soft_int_m  <= 1'b0;
    end else begin
      tpend_q           <= cmp;
      spend_q           <= msip_q;
      timer_int_m       <= cmp & ~tpend_q;
      clear_timer_int_m <= ~cmp & tpend_q;
      soft_int_m        <= msip_q & ~spend_q;
      clear_soft_int_m  <= ~msip_q & spend_q;
    end
  end

endmodule

// File: tb/tb_priv_1_12_clint.sv
// Directed bench for priv_1_12_clint: one instance at TICK_DIV=1, one at TICK_DIV=4,
// both on the same bus.
module tb_priv_1_12_clint;

  localparam logic [31:0] B = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ren = 1'b0, wen = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  byte_en = '0;

  logic [31:0] rdata1, rdata4;
  logic        ack1, err1, ti1, cti1, si1, csi1;
  logic        ack4, err4, ti4, cti4, si4, csi4;

  int checks = 0;
  int failures = 0;
  int cyc;

  int tset_n = 0, tset_at = -1, tclr_n = 0, tclr_at = -1;
  int sset_n = 0, sset_at = -1, sclr_n = 0, sclr_at = -1;

  logic [31:0] r1, r4;
  logic        e1, fast;
  int          acc;

  always #5 clk = ~clk;

  priv_1_12_clint #(.BASE_ADDR(B), .TICK_DIV(1)) u_dut1 (
    .CLK(clk), .nRST(rst_n), .ren(ren), .wen(wen), .addr(addr), .wdata(wdata),
    .byte_en(byte_en), .rdata(rdata1), .ack(ack1), .err(err1), .timer_int_m(ti1),
    .clear_timer_int_m(cti1), .soft_int_m(si1), .clear_soft_int_m(csi1)
  );

  priv_1_12_clint #(.BASE_ADDR(B), .TICK_DIV(4)) u_dut4 (
    .CLK(clk), .nRST(rst_n), .ren(ren), .wen(wen), .addr(addr), .wdata(wdata),
    .byte_en(byte_en), .rdata(rdata4), .ack(ack4), .err(err4), .timer_int_m(ti4),
    .clear_timer_int_m(cti4), .soft_int_m(si4), .clear_soft_int_m(csi4)
  );

  // Edges seen since reset release; equals mtime of the TICK_DIV=1 instance if never written.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (ti1)  begin tset_n <= tset_n + 1; tset_at <= cyc; end
    if (cti1) begin tclr_n <= tclr_n + 1; tclr_at <= cyc; end
    if (si1)  begin sset_n <= sset_n + 1; sset_at <= cyc; end
    if (csi1) begin sclr_n <= sclr_n + 1; sclr_at <= cyc; end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, got no finish want finish");
    $fatal(1);
  end

  // One bus transaction; acc is the edge count at which the request was accepted.
  task automatic xfer(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
    logic done;
    @(negedge clk);
    ren = r; wen = w; addr = a; wdata = d; byte_en = be;
    fast = 1'b1; done = 1'b0; acc = -1; r1 = '0; r4 = '0; e1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!done) begin
        @(negedge clk);
        if (ack1) begin
          r1 = rdata1; r4 = rdata4; e1 = err1; acc = cyc; done = 1'b1;
        end else begin
          fast = 1'b0;
        end
      end
    end
    ren = 1'b0; wen = 1'b0;
    if (!done) acc = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ack1, err1, ti1, cti1, si1, csi1} !== 6'b0) begin
      failures++; $display("FAIL reset_outputs: got %b want 000000", {ack1, err1, ti1, cti1, si1, csi1});
    end
    checks++;
    if (rdata1 !== 32'h0) begin
      failures++; $display("FAIL reset_rdata: got %h want 00000000", rdata1);
    end
    rst_n = 1'b1;
    xfer(1'b1, 1'b0, B + 32'h4004, 32'h0, 4'hF);
    checks++;
    if (fast !== 1'b1) begin
      failures++; $display("FAIL read_ack_latency: got %b want 1", fast);
    end
    checks++;
    if (r1 !== 32'hFFFF_FFFF || e1 !== 1'b0) begin
      failures++; $display("FAIL reset_mtimecmp_hi: got %h err %b want ffffffff err 0", r1, e1);
    end
  endtask

  task automatic test_mtime_count();
    repeat (10) @(negedge clk);
    xfer(1'b1, 1'b0, B + 32'hBFF8, 32'h0, 4'hF);
    checks++;
    if (r1 !== 32'(acc - 1)) begin
      failures++; $display("FAIL mtime_div1: got %0d want %0d", r1, acc - 1);
    end
    checks++;
    if (r4 !== 32'((acc - 1) / 4)) begin
      failures++; $display("FAIL mtime_div4: got %0d want %0d", r4, (acc - 1) / 4);
    end
  endtask

  task automatic test_timer();
    int w0, c, n0, n1;
    n0 = tset_n;
    xfer(1'b0, 1'b1, B + 32'hBFF8, 32'h0, 4'hF);
    w0 = acc;
    xfer(1'b0, 1'b1, B + 32'h4004, 32'h0, 4'hF);
    xfer(1'b0, 1'b1, B + 32'h4000, 32'd20, 4'hF);
    while (cyc < w0 + 30) @(negedge clk);
    checks++;
    if (tset_n - n0 !== 1 || tset_at !== w0 + 21) begin
      failures++;
      $display("FAIL timer_set: got %0d pulses at %0d want 1 at %0d", tset_n - n0, tset_at, w0 + 21);
    end
    n1 = tclr_n;
    xfer(1'b0, 1'b1, B + 32'h4004, 32'hFFFF_FFFF, 4'hF);
    c = acc;
    repeat (4) @(negedge clk);
    checks++;
    if (tclr_n - n1 !== 1 || tclr_at !== c + 1) begin
      failures++;
      $display("FAIL timer_clear: got %0d pulses at %0d want 1 at %0d", tclr_n - n1, tclr_at, c + 1);
    end
    checks++;
    if (tset_n - n0 !== 1) begin
      failures++; $display("FAIL timer_no_reset_pulse: got %0d want 1", tset_n - n0);
    end
  endtask

  task automatic test_soft();
    int s, n0, n1, m0, m1;
    n0 = sset_n;
    xfer(1'b0, 1'b1, B, 32'h1, 4'hF);
    s = acc;
    repeat (3) @(negedge clk);
    checks++;
    if (sset_n - n0 !== 1 || sset_at !== s + 1) begin
      failures++;
      $display("FAIL soft_set: got %0d pulses at %0d want 1 at %0d", sset_n - n0, sset_at, s + 1);
    end
    n1 = sclr_n;
    xfer(1'b0, 1'b1, B, 32'h0, 4'hF);
    s = acc;
    repeat (3) @(negedge clk);
    checks++;
    if (sclr_n - n1 !== 1 || sclr_at !== s + 1) begin
      failures++;
      $display("FAIL soft_clear: got %0d pulses at %0d want 1 at %0d", sclr_n - n1, sclr_at, s + 1);
    end
    m0 = sset_n; m1 = sclr_n;
    xfer(1'b0, 1'b1, B, 32'h1, 4'b1110);
    repeat (4) @(negedge clk);
    checks++;
    if (sset_n !== m0 || sclr_n !== m1) begin
      failures++; $display("FAIL soft_byte_en: got %0d/%0d pulses want 0/0", sset_n - m0, sclr_n - m1);
    end
    xfer(1'b1, 1'b0, B, 32'h0, 4'hF);
    checks++;
    if (r1 !== 32'h0) begin
      failures++; $display("FAIL soft_byte_en_read: got %h want 00000000", r1);
    end
  endtask

  task automatic test_wrap();
    int b, t;
    while (cyc % 4 != 3) @(negedge clk);
    xfer(1'b0, 1'b1, B + 32'hBFF8, 32'hFFFF_FFFE, 4'hF);
    xfer(1'b0, 1'b1, B + 32'hBFFC, 32'hFFFF_FFFF, 4'hF);
    b = acc;
    // Ticks land at b+1 and b+5, so mtime reads 0 from b+5 through b+8.
    while (cyc < b + 4) @(negedge clk);
    xfer(1'b1, 1'b0, B + 32'hBFF8, 32'h0, 4'hF);
    checks++;
    if (r4 !== 32'h0) begin
      failures++; $display("FAIL wrap_lo: got %h want 00000000", r4);
    end
    xfer(1'b1, 1'b0, B + 32'hBFFC, 32'h0, 4'hF);
    checks++;
    if (r4 !== 32'h0) begin
      failures++; $display("FAIL wrap_hi: got %h want 00000000", r4);
    end
    while (cyc % 4 != 2) @(negedge clk);
    xfer(1'b0, 1'b1, B + 32'hBFF8, 32'h1234_5678, 4'hF);
    t = acc;
    xfer(1'b1, 1'b0, B + 32'hBFF8, 32'h0, 4'hF);
    checks++;
    if (r4 !== 32'h1234_5678 || t % 4 != 0) begin
      failures++; $display("FAIL tick_write_lo: got %h at %0d want 12345678 at tick", r4, t);
    end
    xfer(1'b1, 1'b0, B + 32'hBFFC, 32'h0, 4'hF);
    checks++;
    if (r4 !== 32'h0) begin
      failures++; $display("FAIL tick_write_hi: got %h want 00000000", r4);
    end
    xfer(1'b1, 1'b0, B + 32'hBFF8, 32'h0, 4'hF);
    checks++;
    if (r4 !== 32'h1234_5679) begin
      failures++; $display("FAIL tick_after_write: got %h want 12345679", r4);
    end
  endtask

  task automatic test_bad_access();
    int n0;
    xfer(1'b1, 1'b0, B + 32'h0008, 32'h0, 4'hF);
    checks++;
    if (e1 !== 1'b1 || r1 !== 32'h0 || acc < 0) begin
      failures++; $display("FAIL bad_unmapped: got err %b rdata %h want err 1 rdata 0", e1, r1);
    end
    xfer(1'b0, 1'b1, B + 32'h4001, 32'h0, 4'hF);
    checks++;
    if (e1 !== 1'b1) begin
      failures++; $display("FAIL bad_misaligned: got err %b want 1", e1);
    end
    xfer(1'b1, 1'b0, B + 32'h4000, 32'h0, 4'hF);
    checks++;
    if (r1 !== 32'd20 || e1 !== 1'b0) begin
      failures++; $display("FAIL bad_no_side_effect: got %h err %b want 00000014 err 0", r1, e1);
    end
    n0 = sset_n;
    xfer(1'b1, 1'b1, B, 32'h1, 4'hF);
    checks++;
    if (e1 !== 1'b1 || r1 !== 32'h0) begin
      failures++; $display("FAIL bad_ren_wen: got err %b rdata %h want err 1 rdata 0", e1, r1);
    end
    xfer(1'b1, 1'b0, B, 32'h0, 4'hF);
    repeat (2) @(negedge clk);
    checks++;
    if (r1 !== 32'h0 || sset_n !== n0) begin
      failures++; $display("FAIL bad_ren_wen_msip: got %h pulses %0d want 0 0", r1, sset_n - n0);
    end
    xfer(1'b1, 1'b0, 32'h0300_4000, 32'h0, 4'hF);
    checks++;
    if (e1 !== 1'b1 || r1 !== 32'h0) begin
      failures++; $display("FAIL bad_out_of_window: got err %b rdata %h want err 1 rdata 0", e1, r1);
    end
  endtask

  task automatic test_reset_mid();
    xfer(1'b0, 1'b1, B, 32'h1, 4'hF);
    @(negedge clk);
    ren = 1'b1; addr = B + 32'h4000;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    ren = 1'b0;
    #1;
    checks++;
    if (ack1 !== 1'b0) begin
      failures++; $display("FAIL reset_mid_ack: got %b want 0", ack1);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({ack1, err1, ti1, cti1, si1, csi1} !== 6'b0 || rdata1 !== 32'h0) begin
      failures++; $display("FAIL reset_mid_outputs: got %b rdata %h want 000000 rdata 0",
                           {ack1, err1, ti1, cti1, si1, csi1}, rdata1);
    end
    rst_n = 1'b1;
    xfer(1'b1, 1'b0, B + 32'h4000, 32'h0, 4'hF);
    checks++;
    if (fast !== 1'b1 || r1 !== 32'hFFFF_FFFF || e1 !== 1'b0) begin
      failures++; $display("FAIL reset_mid_cmp_lo: got %h ack_fast %b want ffffffff 1", r1, fast);
    end
    xfer(1'b1, 1'b0, B, 32'h0, 4'hF);
    checks++;
    if (r1 !== 32'h0) begin
      failures++; $display("FAIL reset_mid_msip: got %h want 00000000", r1);
    end
    xfer(1'b1, 1'b0, B + 32'hBFF8, 32'h0, 4'hF);
    checks++;
    if (r1 !== 32'(acc - 1)) begin
      failures++; $display("FAIL reset_mid_mtime: got %0d want %0d", r1, acc - 1);
    end
  endtask

  initial begin
    test_reset();
    test_mtime_count();
    test_timer();
    test_soft();
    test_wrap();
    test_bad_access();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
